result_drain: RTL



---
 rtl/result_drain_pkg.sv | 21 ++
 rtl/result_drain_ram.sv | 37 +++
 rtl/result_drain.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/result_drain_pkg.sv
// Shared configuration for the result drain: word/address widths and FSM encoding.
// Pure declarations, no logic, so there is no latency or backpressure.
// DATA_WIDTH / ADDR_SIZE come from the accelerator config defines when present.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 12
`endif

package result_drain_pkg;

    localparam int RD_DATA_WIDTH = `DATA_WIDTH;
    localparam int RD_ADDR_SIZE  = `ADDR_SIZE;

    // FSM encoding (kept as plain constants for legacy tooling)
    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_READY   = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/result_drain_ram.sv
// Simple dual-port result RAM: one write port, one synchronous read port, no array reset.
// Read latency 1 cycle; a write at edge N is visible to a read issued at edge N+1.
// No backpressure: every enabled access completes.
//
// Ports: clk; i_we/i_waddr/i_wdat write port; i_re/i_raddr read request; o_rdat read data.
module result_drain_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 12,
    parameter int DEPTH      = 2**ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_SIZE-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdat,
    input  logic                  i_re,
    input  logic [ADDR_SIZE-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdat
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdat <= r_mem[i_raddr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/result_drain.sv
// Captures result-writer words into a local RAM, then streams them out in address order.
// Latency: rd_start at edge N -> first m_valid after edge N+2; 1 beat/cycle thereafter.
// Backpressure: m_ready low stalls a 2-entry skid FIFO; RAM reads stop when it is full.
//
// Ports: clk, rst (sync, active-high); i_result_* write port and i_w_done from the
// result writer; rd_start request; m_data/m_valid/m_ready/m_last output stream;
// ready_to_drain, done pulse, word_count (latched length), err (sticky).
// Optional feature: define RESULT_DRAIN_HOLE_CHECK_EN to track written addresses;
// unwritten addresses then drain as 0 and set err.
module result_drain
    import result_drain_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int DEPTH      = 2**ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_SIZE-1:0]  i_result_addr,
    input  logic [DATA_WIDTH-1:0] i_result_save,
    input  logic                  i_result_w_ena,
    input  logic                  i_result_w_vld,
    input  logic                  i_w_done,
    input  logic                  rd_start,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  ready_to_drain,
    output logic                  done,
    output logic [ADDR_SIZE:0]    word_count,
    output logic                  err
);

    localparam int CW = ADDR_SIZE + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // control state
    logic [1:0]    r_state;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_word_count;
    logic [CW-1:0] r_rd_ptr;
    logic          r_done;
    logic          r_err;

    // read in flight: RAM data appears the cycle after issue
    logic          r_rd_vld;
    logic          r_rd_last;
    logic          r_rd_hole;

    // 2-entry skid FIFO
    logic [DATA_WIDTH-1:0] r_fifo_dat  [2];
    logic                  r_fifo_last [2];
    logic                  r_fifo_rptr;
    logic                  r_fifo_wptr;
    logic [1:0]            r_fifo_cnt;

    logic                  w_wr_req;
    logic                  w_in_range;
    logic                  w_wr_ok;
    logic [CW-1:0]         w_addr_p1;
    logic [CW-1:0]         w_len_nxt;
    logic                  w_pop;
    logic                  w_pop_last;
    logic                  w_push;
    logic [2:0]            w_occ;
    logic                  w_rd_issue;
    logic                  w_rd_hole_nxt;
    logic [DATA_WIDTH-1:0] w_ram_rdat;
    logic [DATA_WIDTH-1:0] w_push_dat;
    logic                  w_proto_err;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign w_wr_req   = i_result_w_ena & i_result_w_vld;
    assign w_in_range = ({1'b0, i_result_addr} < DEPTH_C);
    assign w_wr_ok    = w_wr_req && (r_state == ST_COLLECT) && w_in_range;
    assign w_addr_p1  = {1'b0, i_result_addr} + CW'(1);
    // Length is the highest written address + 1, so out-of-order writes are fine.
    assign w_len_nxt  = (w_wr_ok && (w_addr_p1 > r_len)) ? w_addr_p1 : r_len;

    // Anything from the writer outside COLLECT is a protocol violation.
    assign w_proto_err = (r_state != ST_COLLECT) && (w_wr_req || i_w_done);

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign m_valid    = (r_fifo_cnt != 2'd0);
    assign m_data     = r_fifo_dat[r_fifo_rptr];
    assign m_last     = m_valid & r_fifo_last[r_fifo_rptr];
    assign w_pop      = m_valid & m_ready;
    assign w_pop_last = w_pop & m_last;
    assign w_push     = r_rd_vld;

    // Occupancy after this cycle's pop plus the read already in flight. Counting
    // the pop as freeing a slot now is what keeps the stream bubble-free.
    assign w_occ      = {1'b0, r_fifo_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
    assign w_rd_issue = (r_state == ST_DRAIN) && (r_rd_ptr < r_word_count) && (w_occ < 3'd2);

`ifdef RESULT_DRAIN_HOLE_CHECK_EN
    logic [DEPTH-1:0] r_written;

    always_ff @(posedge clk) begin
        if (rst || r_done) begin
            r_written <= '0;
        end else if (w_wr_ok) begin
            r_written[i_result_addr] <= 1'b1;
        end
    end

    assign w_rd_hole_nxt = ~r_written[r_rd_ptr[ADDR_SIZE-1:0]];
    assign w_push_dat    = r_rd_hole ? '0 : w_ram_rdat;
`else
    assign w_rd_hole_nxt = 1'b0;
    assign w_push_dat    = w_ram_rdat;
`endif

    result_drain_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_SIZE  (ADDR_SIZE),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (i_result_addr),
        .i_wdat  (i_result_save),
        .i_re    (w_rd_issue),
        .i_raddr (r_rd_ptr[ADDR_SIZE-1:0]),
        .o_rdat  (w_ram_rdat)
    );

    // ------------------------------------------------------------------
    // Control FSM and length tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_COLLECT;
            r_len        <= '0;
            r_word_count <= '0;
            r_rd_ptr     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    r_len <= w_len_nxt;
                    if (i_w_done) begin
                        r_state      <= ST_READY;
                        r_word_count <= w_len_nxt;
                    end
                end
                ST_READY: begin
                    if (rd_start) begin
                        r_rd_ptr <= '0;
                        if (r_word_count == '0) begin
                            r_state <= ST_COLLECT;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_rd_issue) begin
                        r_rd_ptr <= r_rd_ptr + CW'(1);
                    end
                    // The last beat is also the last read, so nothing is left in flight.
                    if (w_pop_last) begin
                        r_state      <= ST_COLLECT;
                        r_done       <= 1'b1;
                        r_len        <= '0;
                        r_word_count <= '0;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    // in-flight read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_hole <= 1'b0;
        end else begin
            r_rd_vld  <= w_rd_issue;
            r_rd_last <= (r_rd_ptr == r_word_count - CW'(1));
            r_rd_hole <= w_rd_hole_nxt;
        end
    end

    // skid FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_dat[i]  <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_fifo_rptr <= 1'b0;
            r_fifo_wptr <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_dat[r_fifo_wptr]  <= w_push_dat;
                r_fifo_last[r_fifo_wptr] <= r_rd_last;
                r_fifo_wptr              <= ~r_fifo_wptr;
            end
            if (w_pop) begin
                r_fifo_rptr <= ~r_fifo_rptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_proto_err
                     || (w_wr_req && (r_state == ST_COLLECT) && !w_in_range)
                     || (w_push && r_rd_hole)) begin
            r_err <= 1'b1;
        end
    end

    assign ready_to_drain = (r_state == ST_READY);
    assign done           = r_done;
    assign word_count     = r_word_count;
    assign err            = r_err;

endmodule
